// File: rtl/aes_dec_iter.sv
// aes_dec_iter: iterative AES inverse cipher, external key store and inverse S-box; `define AES_DEC_ABORT_EN adds abort_i
module aes_dec_iter #(
  parameter int NK = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
`ifdef AES_DEC_ABORT_EN
  input  logic         abort_i,
`endif
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] cyphertext_i,
  output logic [3:0]   rk_idx_o,
  input  logic [127:0] rk_i,
  output logic [127:0] sbox_o,
  input  logic [127:0] sbox_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] plaintext_o,
  output logic         busy_o
);
  localparam logic [3:0] NR = 4'(NK + 6);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  logic [127:0] st_q, st_d;
  logic abort;
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return (m[0] ? b : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
  endfunction
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction
  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
                           gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
                           gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
                           gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)};
    end
    return o;
  endfunction
`ifdef AES_DEC_ABORT_EN
  assign abort = abort_i && state_q != IDLE;
`else
  assign abort = 1'b0;
`endif
  assign in_ready_o  = state_q == IDLE;
  assign busy_o      = state_q != IDLE;
  assign out_valid_o = state_q == DONE;
  assign plaintext_o = st_q;
  assign sbox_o      = inv_shift_rows(st_q);
  assign rk_idx_o    = state_q == IDLE ? NR : state_q == ROUND ? rnd_q : 4'd0;
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    st_d    = st_q;
    case (state_q)
      IDLE: if (in_valid_i) begin
        st_d    = cyphertext_i ^ rk_i;
        rnd_d   = NR - 4'd1;
        state_d = ROUND;
      end
      ROUND: begin
        st_d    = inv_mix_columns(sbox_i ^ rk_i);
        rnd_d   = rnd_q - 4'd1;
        state_d = rnd_q == 4'd1 ? FINAL : ROUND;
      end
      FINAL: begin
        st_d    = sbox_i ^ rk_i;
        state_d = DONE;
      end
      default: state_d = out_ready_i ? IDLE : DONE;
    endcase
    if (abort) begin
      state_d = IDLE;
      rnd_d   = '0;
      st_d    = '0;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
    end
endmodule

// File: tb/tb_aes_dec_iter.sv
// tb_aes_dec_iter: directed FIPS-197 vectors on NK=4/6/8 instances with modelled key store and inverse S-box
module tb_aes_dec_iter;
  typedef struct {
    int           nk;
    logic [255:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;
  logic clk, rst, in_valid, out_ready, abort;
  logic [127:0] ct;
  int sel;
  logic [2:0] ir, ov, bz, iv;
  logic [2:0][3:0] idx;
  logic [2:0][127:0] rk_s, sb_o, sb_i, pt;
  logic [127:0] rks [0:2][0:14];
  logic [7:0] isb [0:255];
  logic [7:0] sb [0:255];
  int n_chk, n_err;
  for (genvar g = 0; g < 3; g++) begin : u
    assign iv[g] = in_valid && sel == g;
    assign rk_s[g] = rks[g][idx[g]];
    aes_dec_iter #(.NK(4 + 2 * g)) dut (
      .clk_i(clk), .rst_i(rst),
`ifdef AES_DEC_ABORT_EN
      .abort_i(abort),
`endif
      .in_valid_i(iv[g]), .in_ready_o(ir[g]), .cyphertext_i(ct),
      .rk_idx_o(idx[g]), .rk_i(rk_s[g]), .sbox_o(sb_o[g]), .sbox_i(sb_i[g]),
      .out_valid_o(ov[g]), .out_ready_i(out_ready), .plaintext_o(pt[g]), .busy_o(bz[g])
    );
  end
  always_comb
    for (int g = 0; g < 3; g++)
      for (int b = 0; b < 16; b++)
        sb_i[g][8*b +: 8] = isb[sb_o[g][8*b +: 8]];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] x, input int k);
    return (x << k) | (x >> (8 - k));
  endfunction
  function automatic logic [127:0] isr_m(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(4*((c+r)%4)+r) -: 8] = s[127-8*(4*c+r) -: 8];
    return o;
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction
  task automatic build_sbox();
    logic [7:0] b, inv;
    for (int y = 0; y < 256; y++) begin
      b = rotl(8'(y), 1) ^ rotl(8'(y), 3) ^ rotl(8'(y), 6) ^ 8'h05;
      inv = 8'h00;
      if (b != 8'h00) begin
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, b);
      end
      isb[y] = inv;
      sb[inv] = 8'(y);
    end
  endtask
  task automatic expand(input int k, input int nk, input logic [255:0] key);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nk + 6; r++) rks[k][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic run(input int s, input logic [127:0] c, input logic [127:0] p, input bit rel);
    int n = 0, bad = 0, nr = 10 + 2 * s;
    sel = s;
    chk("in_ready_idle", 128'(ir[s]), 128'd1);
    ct = c;
    in_valid = 1'b1;
    @(posedge clk) #1;
    in_valid = 1'b0;
    chk("busy_run", 128'(bz[s]), 128'd1);
    while (!ov[s] && n < 40) begin
      if (idx[s] != 4'(n < nr - 1 ? nr - 1 - n : 0)) bad++;
      @(posedge clk) #1;
      n++;
    end
    chk("rk_idx_seq", 128'(bad), 128'd0);
    chk("latency", 128'(n), 128'(nr));
    chk("plaintext", pt[s], p);
    chk("sbox_done", sb_o[s], isr_m(p));
    if (rel) begin
      out_ready = 1'b1;
      @(posedge clk) #1;
      out_ready = 1'b0;
      chk("release_valid", 128'(ov[s]), 128'd0);
      chk("release_ready", 128'(ir[s]), 128'd1);
    end
  endtask
  task automatic quiet(input int s);
    int hits = 0;
    repeat (16) begin
      @(posedge clk) #1;
      if (ov[s]) hits++;
    end
    chk("no_valid_after_kill", 128'(hits), 128'd0);
  endtask
  initial begin
    vec_t vt [5];
    int n, stable;
    logic [127:0] held;
    vt[0] = '{4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff};
    vt[1] = '{4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
              128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734};
    vt[2] = '{4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
              128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'h6bc1bee22e409f96e93d7e117393172a};
    vt[3] = '{6, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
              128'hdda97ca4864cdfe06eaf70a0ec0d7191, 128'h00112233445566778899aabbccddeeff};
    vt[4] = '{8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
              128'h8ea2b7ca516745bfeafc49904b496089, 128'h00112233445566778899aabbccddeeff};
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    abort = 1'b0;
    ct = '0;
    sel = 0;
    build_sbox();
    #2;
    for (int g = 0; g < 3; g++) begin
      chk("rst_out_valid", 128'(ov[g]), 128'd0);
      chk("rst_in_ready", 128'(ir[g]), 128'd1);
      chk("rst_busy", 128'(bz[g]), 128'd0);
      chk("rst_plaintext", pt[g], 128'd0);
      chk("rst_rk_idx", 128'(idx[g]), 128'(10 + 2 * g));
    end
    @(posedge clk);
    @(posedge clk) #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expand((vt[i].nk - 4) / 2, vt[i].nk, vt[i].key);
      run((vt[i].nk - 4) / 2, vt[i].ct, vt[i].pt, 1'b1);
    end
    run(0, vt[1].ct, vt[1].pt, 1'b0);
    held = pt[0];
    stable = 0;
    repeat (20) begin
      @(posedge clk) #1;
      if (pt[0] === held && ov[0] && !ir[0]) stable++;
    end
    chk("backpressure_cycles", 128'(stable), 128'd20);
    chk("backpressure_pt", pt[0], vt[1].pt);
    out_ready = 1'b1;
    @(posedge clk) #1;
    out_ready = 1'b0;
    chk("bp_release_ready", 128'(ir[0]), 128'd1);
    sel = 0;
    ct = vt[1].ct;
    in_valid = 1'b1;
    out_ready = 1'b1;
    n = 0;
    while (!ov[0] && n < 40) begin
      @(posedge clk) #1;
      n++;
    end
    chk("b2b_first_lat", 128'(n), 128'd11);
    chk("b2b_first_pt", pt[0], vt[1].pt);
    ct = vt[2].ct;
    n = 0;
    do begin
      @(posedge clk) #1;
      n++;
    end while (!ov[0] && n < 40);
    in_valid = 1'b0;
    chk("b2b_gap", 128'(n), 128'd12);
    chk("b2b_second_pt", pt[0], vt[2].pt);
    @(posedge clk) #1;
    out_ready = 1'b0;
    chk("b2b_idle", 128'(ir[0]), 128'd1);
    ct = vt[2].ct;
    in_valid = 1'b1;
    @(posedge clk) #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk) #1;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 128'(ov[0]), 128'd0);
    chk("midrst_busy", 128'(bz[0]), 128'd0);
    chk("midrst_ready", 128'(ir[0]), 128'd1);
    chk("midrst_pt", pt[0], 128'd0);
    @(posedge clk) #1;
    rst = 1'b0;
    quiet(0);
    run(0, vt[2].ct, vt[2].pt, 1'b1);
`ifdef AES_DEC_ABORT_EN
    ct = vt[1].ct;
    in_valid = 1'b1;
    @(posedge clk) #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk) #1;
    abort = 1'b1;
    @(posedge clk) #1;
    abort = 1'b0;
    chk("abort_ready", 128'(ir[0]), 128'd1);
    chk("abort_busy", 128'(bz[0]), 128'd0);
    chk("abort_st", pt[0], 128'd0);
    quiet(0);
    run(0, vt[1].ct, vt[1].pt, 1'b1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/aes_dec_iter.md
AES_DEC_ITER -- requirements
Module: aes_dec_iter

Interface
REQ-001 SHALL have parameter NK, default 4, key length in 32-bit words; legal values 4/6/8; round count NR = NK+6 (10/12/14).
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_valid_i, input, 1, cyphertext offered.
REQ-005 SHALL have port in_ready_o, output, 1, block can accept a cyphertext.
REQ-006 SHALL have port cyphertext_i, input, 128, input block; byte 0 at bits [127:120], column-major per FIPS-197.
REQ-007 SHALL have port rk_idx_o, output, 4, index of the round key required this cycle.
REQ-008 SHALL have port rk_i, input, 128, round key rk_idx_o from the external key store, valid combinationally in the same cycle; same byte order as cyphertext_i.
REQ-009 SHALL have port sbox_o, output, 128, 16 bytes sent to the external inverse S-box array.
REQ-010 SHALL have port sbox_i, input, 128, byte-wise InvSubBytes(sbox_o), combinational, same cycle.
REQ-011 SHALL have port out_valid_o, output, 1, plaintext available.
REQ-012 SHALL have port out_ready_i, input, 1, consumer accepts plaintext.
REQ-013 SHALL have port plaintext_o, output, 128, decrypted block, held stable while out_valid_o=1.
REQ-014 SHALL have port busy_o, output, 1, high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ROUND, FINAL, DONE, with a 4-bit round counter rnd and a 128-bit state register st.
REQ-016 In IDLE: in_ready_o=1, rk_idx_o=NR; on in_valid_i&in_ready_o SHALL load st <= cyphertext_i ^ rk_i, load rnd <= NR-1, and go to ROUND.
REQ-017 In ROUND: sbox_o = InvShiftRows(st), rk_idx_o = rnd; each edge SHALL load st <= InvMixColumns(sbox_i ^ rk_i) and decrement rnd; when rnd=1, SHALL go to FINAL.
REQ-018 In FINAL: sbox_o = InvShiftRows(st), rk_idx_o = 0; SHALL load st <= sbox_i ^ rk_i and go to DONE.
REQ-019 Latency: out_valid_o SHALL rise exactly NR rising edges after the accepting edge (10/12/14).
REQ-020 In DONE: out_valid_o=1, plaintext_o=st; on out_ready_i=1 SHALL return to IDLE at the next edge; otherwise SHALL hold plaintext_o and out_valid_o unchanged indefinitely.
REQ-021 in_ready_o SHALL be 0 in ROUND/FINAL/DONE; in_valid_i is ignored there, with no queuing.
REQ-022 An edge with out_ready_i=1 in DONE and in_valid_i=1 SHALL NOT accept the new block; it is accepted no earlier than the following IDLE cycle.
REQ-023 Outside ROUND/FINAL, sbox_o SHALL equal InvShiftRows(st).
REQ-024 InvShiftRows and InvMixColumns SHALL be internal GF(2^8) logic (poly 0x11B); no multipliers or memories.

Reset
REQ-025 rst_i=1 SHALL asynchronously force state IDLE, rnd=0, st=0, out_valid_o=0, in_ready_o=1 (combinational from IDLE), busy_o=0, plaintext_o=0.
REQ-026 Reset asserted mid-operation SHALL discard the block in flight; no out_valid_o pulse follows.
REQ-027 After rst_i deasserts, a block SHALL be accepted on the first edge with in_valid_i=1.

Configuration
REQ-028 Macro AES_DEC_ABORT_EN: when defined, input port abort_i (1 bit) SHALL exist; abort_i=1 in ROUND, FINAL or DONE SHALL return the FSM to IDLE at the next edge with out_valid_o=0 and st cleared; abort_i is ignored in IDLE; abort_i takes priority over out_ready_i.
REQ-029 When AES_DEC_ABORT_EN is undefined, port abort_i SHALL be absent and behaviour is as in REQ-015..REQ-027.

Verification (the bench models the key store from FIPS-197 key expansion and the inverse S-box)
REQ-030 NK=4, key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff, out_valid_o exactly 10 edges after acceptance.
REQ-031 NK=6, key 000102...1617, ct dda97ca4864cdfe06eaf70a0ec0d7191 -> same pt after 12 edges; NK=8, key 000102...1e1f, ct 8ea2b7ca516745bfeafc49904b496089 -> same pt after 14 edges.
REQ-032 Backpressure: out_ready_i=0 for 20 cycles in DONE -> plaintext_o and out_valid_o stable, in_ready_o=0 throughout; then 1 -> IDLE at the next edge.
REQ-033 Back-to-back: in_valid_i held high with two vectors and out_ready_i=1 -> both plaintexts correct; second accept edge is >= 2 edges after the first out_valid_o rise.
REQ-034 rst_i pulsed at round 5 -> outputs return to reset values immediately, no out_valid_o; next vector decrypts correctly.
REQ-035 With AES_DEC_ABORT_EN, abort_i=1 in round 3 -> IDLE next edge, no out_valid_o; a subsequent vector decrypts correctly.
